// File: rtl/lcd_buf_pkg.sv
// -----------------------------------------------------------------------------
// lcd_buf_pkg
// Shared definitions for the LCD text buffer: host control codes, the
// printable character range, the buffer FSM state encoding and a small
// character classification helper.
// -----------------------------------------------------------------------------
package lcd_buf_pkg;

  // Host control codes
  localparam logic [7:0] CH_NL = 8'h0A;  // newline: column 0 of next row
  localparam logic [7:0] CH_BS = 8'h08;  // backspace: step back and blank
  localparam logic [7:0] CH_FF = 8'h0C;  // form feed: home cursor and clear

  // Inclusive bounds of bytes that are stored as characters
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } lcd_state_e;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/lcd_text_buffer_if.sv
// -----------------------------------------------------------------------------
// lcd_text_buffer_if
// Host byte stream into the text buffer (valid/ready handshake).
//   IN_DATA  : host byte
//   IN_VALID : IN_DATA holds a byte to deliver
//   IN_READY : buffer accepts a byte on this clock edge
// A byte transfers on a rising edge where IN_VALID and IN_READY are both 1.
// -----------------------------------------------------------------------------
interface lcd_text_buffer_if;

  logic [7:0] IN_DATA;
  logic       IN_VALID;
  logic       IN_READY;

  // Host side
  modport master (
    output IN_DATA,
    output IN_VALID,
    input  IN_READY
  );

  // Text buffer side
  modport slave (
    input  IN_DATA,
    input  IN_VALID,
    output IN_READY
  );

endinterface

// File: rtl/lcd_buf_ram.sv
// -----------------------------------------------------------------------------
// lcd_buf_ram
// Simple dual-port DEPTH x 8 character store. One synchronous write port and
// one registered read port. A read and a write to the same address on the
// same edge return the previous contents (read-before-write). No reset: the
// owner initialises the contents by sweeping the write port.
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address, sampled every edge
//   o_rdata : data at i_raddr from the previous edge
// -----------------------------------------------------------------------------
module lcd_buf_ram #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  // Registered read and synchronous write; the read samples the old contents
  always_ff @(posedge i_clk) begin
    r_rdata <= r_mem[i_raddr];
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_text_buffer.sv
// -----------------------------------------------------------------------------
// lcd_text_buffer
// Character buffer and cursor engine in front of the LCD driver. Interprets a
// host byte stream (printable characters plus newline, backspace and form
// feed), keeps a ROWS x COLS display image and a cursor, and serves the image
// through a registered read port. REFRESH_REQ tells the driver that the image
// or cursor changed since its last REFRESH_ACK.
//   CLK          : clock, rising edge
//   RST          : synchronous active-high reset
//   host         : byte stream in (lcd_text_buffer_if.slave)
//   RD_ADDR      : driver read address, row*COLS+col
//   RD_DATA      : character at RD_ADDR from the previous edge
//   REFRESH_REQ  : image changed since the last acknowledge
//   REFRESH_ACK  : one-cycle pulse, driver started a redraw
//   CURSOR       : current write position
//   BUSY         : clear sweep in progress
// -----------------------------------------------------------------------------
module lcd_text_buffer
  import lcd_buf_pkg::*;
#(
  parameter  int         COLS  = 16,
  parameter  int         ROWS  = 2,
  parameter  logic [7:0] BLANK = 8'h20,
  localparam int         DEPTH = ROWS * COLS,
  localparam int         AW    = $clog2(DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  lcd_text_buffer_if.slave        host,
  input  logic [AW-1:0]           RD_ADDR,
  output logic [7:0]              RD_DATA,
  output logic                    REFRESH_REQ,
  input  logic                    REFRESH_ACK,
  output logic [AW-1:0]           CURSOR,
  output logic                    BUSY
);

  localparam logic [0:0]    S_CLEAR   = 1'(CLEAR);
  localparam logic [0:0]    S_IDLE    = 1'(IDLE);
  localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_W     = AW'(1);

  // Registered state
  logic [0:0]    r_state;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] r_cursor;
  logic          r_in_ready;
  logic          r_busy;
  logic          r_req;
  logic          r_rd_valid;

  // Next-state and datapath wires
  logic [0:0]    w_state_nx;
  logic [AW-1:0] w_idx_nx;
  logic [AW-1:0] w_cursor_nx;
  logic          w_req_nx;
  logic          w_accept;
  logic          w_we;
  logic          w_ram_we;
  logic [AW-1:0] w_waddr;
  logic [7:0]    w_wdata;
  logic          w_event;
  logic [7:0]    w_ram_q;
  logic [31:0]   w_row;
  logic [AW-1:0] w_nl_cursor;
  logic [AW-1:0] w_inc_cursor;
  logic [AW-1:0] w_dec_cursor;

  // IN_READY is only ever high in IDLE, so it alone qualifies acceptance
  assign w_accept = host.IN_VALID && r_in_ready;

  // Cursor candidates: advance with wrap, newline with row wrap, step back
  always_comb begin
    w_row = 32'(r_cursor) / 32'(COLS);
    if (w_row >= 32'(ROWS - 1)) begin
      w_nl_cursor = '0;
    end else begin
      w_nl_cursor = AW'((w_row + 32'd1) * 32'(COLS));
    end
    if (r_cursor == LAST_CELL) begin
      w_inc_cursor = '0;
    end else begin
      w_inc_cursor = r_cursor + ONE_W;
    end
    w_dec_cursor = r_cursor - ONE_W;
  end

  // FSM next state, memory write port and change-event detection
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_cursor_nx = r_cursor;
    w_we        = 1'b0;
    w_waddr     = r_cursor;
    w_wdata     = BLANK;
    w_event     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        // BUSY is low only on the first edge after reset; that edge raises
        // BUSY so the sweep always spans DEPTH cycles of BUSY.
        if (r_busy) begin
          w_we    = 1'b1;
          w_waddr = r_idx;
          if (r_idx == LAST_CELL) begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_event    = 1'b1;
          end else begin
            w_idx_nx = r_idx + ONE_W;
          end
        end else begin
          w_idx_nx = '0;
        end
      end
      S_IDLE: begin
        if (w_accept) begin
          if (is_printable(host.IN_DATA)) begin
            w_we        = 1'b1;
            w_waddr     = r_cursor;
            w_wdata     = host.IN_DATA;
            w_cursor_nx = w_inc_cursor;
            w_event     = 1'b1;
          end else begin
            case (host.IN_DATA)
              CH_NL: begin
                w_cursor_nx = w_nl_cursor;
                w_event     = (w_nl_cursor != r_cursor);
              end
              CH_BS: begin
                if (r_cursor != '0) begin
                  w_we        = 1'b1;
                  w_waddr     = w_dec_cursor;
                  w_cursor_nx = w_dec_cursor;
                  w_event     = 1'b1;
                end else begin
                  w_event = 1'b0;
                end
              end
              CH_FF: begin
                w_cursor_nx = '0;
                w_state_nx  = S_CLEAR;
                w_idx_nx    = '0;
                w_event     = (r_cursor != '0);
              end
              default: begin
                w_event = 1'b0;
              end
            endcase
          end
        end else begin
          w_event = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_CLEAR;
        w_idx_nx   = '0;
      end
    endcase
  end

  // A change event wins over an acknowledge arriving on the same edge
  always_comb begin
    if (w_event) begin
      w_req_nx = 1'b1;
    end else if (REFRESH_ACK) begin
      w_req_nx = 1'b0;
    end else begin
      w_req_nx = r_req;
    end
  end

  // State registers; BUSY/IN_READY are registered from the next state
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_CLEAR;
      r_idx      <= '0;
      r_cursor   <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_req      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_cursor   <= w_cursor_nx;
      r_in_ready <= (w_state_nx == S_IDLE);
      r_busy     <= (w_state_nx == S_CLEAR);
      r_req      <= w_req_nx;
      r_rd_valid <= 1'b1;
    end
  end

  // No writes land while reset is held
  assign w_ram_we = w_we && !RST;

  lcd_buf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (RD_ADDR),
    .o_rdata (w_ram_q)
  );

  // The RAM read register has no reset; mask it to zero until after reset
  assign RD_DATA       = r_rd_valid ? w_ram_q : 8'h00;
  assign host.IN_READY = r_in_ready;
  assign REFRESH_REQ   = r_req;
  assign CURSOR        = r_cursor;
  assign BUSY          = r_busy;

endmodule
